// File: rtl/axis_rr_arbiter_if.sv
// Stream bundle between NUM_SRC sources, the round-robin arbiter and the fifo write port.
// The master modport is the arbiter's view; slave is the surrounding sources and fifo.
interface axis_rr_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_SRC*WIDTH-1:0] S_TData;
    logic [NUM_SRC-1:0]       S_TValid;
    logic [NUM_SRC-1:0]       S_TLast;
    logic [NUM_SRC-1:0]       S_TReady;
    logic [WIDTH-1:0]         M_TData;
    logic                     M_TValid;
    logic                     M_TLast;
    logic                     M_TReady;

    modport master (
        input  S_TData, S_TValid, S_TLast, M_TReady,
        output S_TReady, M_TData, M_TValid, M_TLast
    );

    modport slave (
        output S_TData, S_TValid, S_TLast, M_TReady,
        input  S_TReady, M_TData, M_TValid, M_TLast
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin packet arbiter: locks one source per packet onto the fifo write port and
// forces TLast once a packet reaches MAX_BEATS beats.
module axis_rr_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                 CLK,
    input  logic                 Reset,
    axis_rr_arbiter_if.master    bus,
    output logic [NUM_SRC-1:0]   Grant,
    output logic                 Busy,
    output logic                 Truncated
);
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(MAX_BEATS);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               trunc_q, trunc_d;

    logic [PTR_W-1:0]   sel;
    logic               req_found;
    logic               src_last;
    logic               eff_last;
    logic               accept;
    logic [NUM_SRC-1:0] s_ready;
    logic [WIDTH-1:0]   masked_data [NUM_SRC];
    logic [WIDTH-1:0]   m_data;

    // The one-hot grant doubles as the passthrough mux select, so IDLE drives nothing.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_lane
            assign s_ready[gi]     = grant_q[gi] & bus.M_TReady;
            assign masked_data[gi] = grant_q[gi] ? bus.S_TData[gi*WIDTH +: WIDTH] : '0;
        end
    endgenerate

    always_comb begin
        m_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            m_data = m_data | masked_data[i];
        end
    end

    assign src_last      = |(grant_q & bus.S_TLast);
    assign eff_last      = src_last | (cnt_q == CNT_W'(MAX_BEATS - 1));
    assign bus.M_TValid  = |(grant_q & bus.S_TValid);
    assign bus.M_TLast   = bus.M_TValid & eff_last;
    assign bus.M_TData   = m_data;
    assign bus.S_TReady  = s_ready;
    assign accept        = bus.M_TValid & bus.M_TReady;

    // First requester at or above the pointer, wrapping modulo NUM_SRC.
    always_comb begin
        int idx;
        sel       = '0;
        req_found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!req_found && bus.S_TValid[idx]) begin
                req_found = 1'b1;
                sel       = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        trunc_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    state_d = LOCK;
                    grant_d = NUM_SRC'(1) << sel;
                    owner_d = sel;
                    cnt_d   = '0;
                end
            end
            LOCK: begin
                if (accept) begin
                    if (eff_last) begin
                        state_d = IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                        ptr_d   = (owner_q == PTR_W'(NUM_SRC - 1)) ? '0 : owner_q + 1'b1;
                        trunc_d = ~src_last;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    assign Grant     = grant_q;
    assign Busy      = (state_q == LOCK);
    assign Truncated = trunc_q;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-source beat queues feed the sources, and a
// monitor checks every beat the fifo side accepts against a queue of expected beats.
module tb_axis_rr_arbiter;
    localparam int NUM_SRC   = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BEATS = 16;
    localparam int DEPTH     = 64;

    typedef struct {
        logic [3:0] grant;
        logic [7:0] data;
        logic       last;
        logic       trunc;
    } exp_t;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    logic [NUM_SRC-1:0] Grant;
    logic Busy;
    logic Truncated;

    axis_rr_arbiter_if #(.NUM_SRC(NUM_SRC), .WIDTH(WIDTH)) bus ();

    axis_rr_arbiter #(.NUM_SRC(NUM_SRC), .WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .bus       (bus),
        .Grant     (Grant),
        .Busy      (Busy),
        .Truncated (Truncated)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    exp_t expq[$];
    logic [7:0] src_data [NUM_SRC][DEPTH];
    logic       src_lst  [NUM_SRC][DEPTH];
    int         src_wr   [NUM_SRC];
    int         src_rd   [NUM_SRC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic src_beat(input int s, input logic [7:0] d, input logic l);
        src_data[s][src_wr[s]] = d;
        src_lst[s][src_wr[s]]  = l;
        src_wr[s]++;
    endtask

    task automatic exp_beat(input logic [3:0] g, input logic [7:0] d, input logic l, input logic t);
        exp_t e;
        e.grant = g;
        e.data  = d;
        e.last  = l;
        e.trunc = t;
        expq.push_back(e);
    endtask

    function automatic bit src_pending();
        bit p = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_rd[i] != src_wr[i]) p = 1'b1;
        end
        return p;
    endfunction

    // Source driver: pops a beat after it handshakes, re-drives one step after the edge.
    initial begin
        logic [NUM_SRC-1:0] fire;
        logic [NUM_SRC-1:0] v;
        logic [NUM_SRC-1:0] l;
        logic [NUM_SRC*WIDTH-1:0] d;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        bus.S_TValid = '0;
        bus.S_TLast  = '0;
        bus.S_TData  = '0;
        forever begin
            @(negedge CLK);
            fire = bus.S_TValid & bus.S_TReady & {NUM_SRC{Reset}};
            @(posedge CLK);
            #1;
            v = '0;
            l = '0;
            d = '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (fire[i] && src_rd[i] != src_wr[i]) src_rd[i]++;
                if (src_rd[i] != src_wr[i]) begin
                    v[i] = 1'b1;
                    l[i] = src_lst[i][src_rd[i]];
                    d[i*WIDTH +: WIDTH] = src_data[i][src_rd[i]];
                end
            end
            bus.S_TValid = v;
            bus.S_TLast  = l;
            bus.S_TData  = d;
        end
    end

    // Monitor: compares each accepted beat and the Truncated pulse that may follow it.
    int   mon_cyc = 0;
    int   last_acc_cyc = -10;
    bit   prev_acc = 1'b0;
    bit   prev_trunc = 1'b0;
    bit   prev_last = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            mon_cyc++;
            chk("truncated", 32'(Truncated), 32'(prev_acc ? prev_trunc : 1'b0));
            prev_acc = 1'b0;
            if (Reset) chk("nonowner_ready", 32'(bus.S_TReady & ~Grant), 32'd0);
            if (Reset && bus.M_TValid && bus.M_TReady) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got data 0x%0h grant %b, required no beat",
                             bus.M_TData, Grant);
                end else begin
                    e = expq.pop_front();
                    $display("beat: grant=%b data=%h last=%b", Grant, bus.M_TData, bus.M_TLast);
                    chk("beat_grant", 32'(Grant), 32'(e.grant));
                    chk("beat_data", 32'(bus.M_TData), 32'(e.data));
                    chk("beat_last", 32'(bus.M_TLast), 32'(e.last));
                    if (prev_last) chk("bubble_gap", 32'(mon_cyc - last_acc_cyc >= 2), 32'd1);
                    prev_acc     = 1'b1;
                    prev_trunc   = e.trunc;
                    prev_last    = e.last;
                    last_acc_cyc = mon_cyc;
                end
            end
        end
    end

    task automatic wait_grant(input logic [3:0] mask, input int budget);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (Grant !== mask && n < budget);
        chk("wait_grant", 32'(Grant), 32'(mask));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((expq.size() != 0 || Grant != '0 || src_pending()) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: %0d expected beats left, required 0", expq.size());
            expq.delete();
            for (int i = 0; i < NUM_SRC; i++) src_rd[i] = src_wr[i];
        end
        @(negedge CLK);
    endtask

    initial begin
        bus.M_TReady = 1'b1;
        #1 Reset = 1'b0;

        // Reset with all sources requesting, then fairness across 2-beat packets.
        for (int i = 0; i < NUM_SRC; i++) begin
            src_beat(i, 8'h10 + 8'(i), 1'b0);
            src_beat(i, 8'h20 + 8'(i), 1'b1);
        end
        src_beat(0, 8'h10, 1'b0);
        src_beat(0, 8'h20, 1'b1);
        exp_beat(4'b0001, 8'h10, 1'b0, 1'b0); exp_beat(4'b0001, 8'h20, 1'b1, 1'b0);
        exp_beat(4'b0010, 8'h11, 1'b0, 1'b0); exp_beat(4'b0010, 8'h21, 1'b1, 1'b0);
        exp_beat(4'b0100, 8'h12, 1'b0, 1'b0); exp_beat(4'b0100, 8'h22, 1'b1, 1'b0);
        exp_beat(4'b1000, 8'h13, 1'b0, 1'b0); exp_beat(4'b1000, 8'h23, 1'b1, 1'b0);
        exp_beat(4'b0001, 8'h10, 1'b0, 1'b0); exp_beat(4'b0001, 8'h20, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge CLK);
            chk("rst_grant", 32'(Grant), 32'd0);
            chk("rst_s_ready", 32'(bus.S_TReady), 32'd0);
            chk("rst_m_valid", 32'(bus.M_TValid), 32'd0);
            chk("rst_busy", 32'(Busy), 32'd0);
        end
        Reset = 1'b1;
        @(negedge CLK);
        chk("first_grant", 32'(Grant), 32'b0001);
        chk("first_busy", 32'(Busy), 32'd1);
        wait_done(100);

        // Backpressure: M_TReady 1,0,0,1,1 across the LOCK cycles of a 3-beat packet.
        src_beat(2, 8'h30, 1'b0); src_beat(2, 8'h31, 1'b0); src_beat(2, 8'h32, 1'b1);
        exp_beat(4'b0100, 8'h30, 1'b0, 1'b0);
        exp_beat(4'b0100, 8'h31, 1'b0, 1'b0);
        exp_beat(4'b0100, 8'h32, 1'b1, 1'b0);
        wait_grant(4'b0100, 10);
        chk("bp_c1_data", 32'(bus.M_TData), 32'h30);
        @(posedge CLK); #1 bus.M_TReady = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            @(negedge CLK);
            chk("bp_stall_ready", 32'(bus.S_TReady), 32'd0);
            chk("bp_stall_data", 32'(bus.M_TData), 32'h31);
            chk("bp_stall_valid", 32'(bus.M_TValid), 32'd1);
        end
        @(posedge CLK); #1 bus.M_TReady = 1'b1;
        @(negedge CLK);
        chk("bp_c4_ready", 32'(bus.S_TReady), 32'b0100);
        @(negedge CLK);
        chk("bp_c5_last", 32'(bus.M_TLast), 32'd1);
        chk("bp_c5_data", 32'(bus.M_TData), 32'h32);
        @(negedge CLK);
        chk("bp_c6_grant", 32'(Grant), 32'd0);
        chk("bp_c6_busy", 32'(Busy), 32'd0);
        wait_done(50);

        // Truncation: 20 beats split into a forced 16-beat packet and a 4-beat remainder.
        for (int k = 0; k < 20; k++) src_beat(1, 8'h40 + 8'(k), k == 19);
        for (int k = 0; k < 16; k++) exp_beat(4'b0010, 8'h40 + 8'(k), k == 15, k == 15);
        for (int k = 16; k < 20; k++) exp_beat(4'b0010, 8'h40 + 8'(k), k == 19, 1'b0);
        wait_done(100);

        // Pointer skip: pointer at 2 with only sources 1 and 3 requesting.
        src_beat(3, 8'h73, 1'b1); src_beat(3, 8'h83, 1'b1);
        src_beat(1, 8'h71, 1'b1);
        exp_beat(4'b1000, 8'h73, 1'b1, 1'b0);
        exp_beat(4'b0010, 8'h71, 1'b1, 1'b0);
        exp_beat(4'b1000, 8'h83, 1'b1, 1'b0);
        wait_done(50);

        // Mid-packet reset during beat 2 of a 5-beat packet from source 3.
        for (int k = 0; k < 5; k++) src_beat(3, 8'hC0 + 8'(k), k == 4);
        exp_beat(4'b1000, 8'hC0, 1'b0, 1'b0);
        wait_grant(4'b1000, 10);
        @(posedge CLK);
        #3 Reset = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(Grant), 32'd0);
        chk("mid_rst_s_ready", 32'(bus.S_TReady), 32'd0);
        chk("mid_rst_m_valid", 32'(bus.M_TValid), 32'd0);
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        @(negedge CLK);
        src_rd[3] = src_wr[3];
        src_beat(1, 8'h91, 1'b1);
        for (int k = 0; k < 16; k++) src_beat(3, 8'hA0 + 8'(k), k == 15);
        exp_beat(4'b0010, 8'h91, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) exp_beat(4'b1000, 8'hA0 + 8'(k), k == 15, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b1;
        wait_done(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
